// File: rtl/bandit_ctrl_pkg.sv
// bandit_ctrl_pkg
//   Definitions shared by the bandit sequencer and the blocks that decode
//   its cur_state bus (wait/countdown, reels, score).
//   - state_t : 4-bit game state codes carried on cur_state
//   - sat_inc : saturating increment used for the credit counter
package bandit_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'b0000,
    EVAL = 4'b0001,
    COIN = 4'b0100,
    SPIN = 4'b0101,
    STOP = 4'b0110,
    WAIT = 4'b0111
  } state_t;

  // Increment v by one but never beyond max_v.
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] max_v);
    return (v >= max_v) ? max_v : v + 4'd1;
  endfunction

endpackage

// File: rtl/bandit_ctrl_sec.sv
// sec_tick
//   One-second prescaler. Counts 0..CLK_HZ-1 while en is high and emits a
//   one-cycle tick on the last count. The count is held at 0 whenever en is
//   low, so every enable window starts a fresh second.
//   Ports:
//     clk   in  system clock
//     rst_n in  asynchronous active-low reset
//     en    in  count enable
//     tick  out one-cycle pulse on the final cycle of each second
module sec_tick #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  // Guard against a zero-width counter when CLK_HZ is 1.
  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (!en || cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = en && (cnt_reg == LAST);

endmodule

// File: rtl/bandit_ctrl.sv
// bandit_ctrl
//   Game sequencer for the one-arm bandit. Tracks credits, times the reel
//   spin and drives the shared cur_state bus plus one-cycle control pulses.
//   Ports:
//     clk         in  system clock
//     rst_n       in  asynchronous active-low reset
//     coin_p      in  coin-inserted pulse
//     start_p     in  lever pulse
//     stop_p      in  stop-button pulse
//     score_reset in  wait block countdown expired (level)
//     cur_state   out current state code (state_t)
//     credits     out remaining credits
//     spin_en     out reels rotate while high
//     latch_p     out freeze reel values (during STOP)
//     eval_p      out score evaluates frozen reels (during EVAL)
//     clear_p     out score clears its total (on WAIT -> IDLE)
//   All outputs are registered and change the cycle after their cause.
module bandit_ctrl
  import bandit_ctrl_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SPIN_SEC   = 5,
  parameter int MAX_CREDIT = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_p,
  input  logic       start_p,
  input  logic       stop_p,
  input  logic       score_reset,
  output logic [3:0] cur_state,
  output logic [3:0] credits,
  output logic       spin_en,
  output logic       latch_p,
  output logic       eval_p,
  output logic       clear_p
);

  localparam logic [3:0] MAX_C    = 4'(MAX_CREDIT);
  localparam logic [3:0] SEC_LAST = 4'(SPIN_SEC - 1);

  state_t     state_reg, state_next;
  logic [3:0] credits_reg, credits_next;
  logic [3:0] sec_reg, sec_next;
  logic       spin_en_reg, spin_en_next;
  logic       latch_reg, latch_next;
  logic       eval_reg, eval_next;
  logic       clear_reg, clear_next;

  logic       sec_tick_p;
  logic [3:0] credits_inc;

  sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_reg == SPIN),
    .tick (sec_tick_p)
  );

  assign credits_inc = sat_inc(credits_reg, MAX_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      credits_reg <= '0;
      sec_reg     <= '0;
      spin_en_reg <= 1'b0;
      latch_reg   <= 1'b0;
      eval_reg    <= 1'b0;
      clear_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      credits_reg <= credits_next;
      sec_reg     <= sec_next;
      spin_en_reg <= spin_en_next;
      latch_reg   <= latch_next;
      eval_reg    <= eval_next;
      clear_reg   <= clear_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    credits_next = credits_reg;
    clear_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (coin_p) begin
          credits_next = 4'd1;
          state_next   = COIN;
        end
      end
      COIN: begin
        if (coin_p && start_p) begin
          // Coin is credited before the play is charged, so a full counter
          // ends one below saturation.
          credits_next = credits_inc - 4'd1;
          state_next   = SPIN;
        end else if (start_p && credits_reg != 4'd0) begin
          credits_next = credits_reg - 4'd1;
          state_next   = SPIN;
        end else if (coin_p) begin
          credits_next = credits_inc;
        end
      end
      SPIN: begin
        if (coin_p) credits_next = credits_inc;
        // Time out on the tick that brings the seconds count to SPIN_SEC so
        // the spin lasts exactly SPIN_SEC * CLK_HZ cycles.
        if (stop_p || (sec_tick_p && sec_reg == SEC_LAST)) state_next = STOP;
      end
      STOP: begin
        if (coin_p) credits_next = credits_inc;
        state_next = EVAL;
      end
      EVAL: begin
        if (coin_p) credits_next = credits_inc;
        state_next = (credits_reg != 4'd0 || coin_p) ? COIN : WAIT;
      end
      WAIT: begin
        if (coin_p) begin
          credits_next = 4'd1;
          state_next   = COIN;
        end else if (score_reset) begin
          clear_next = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        credits_next = '0;
      end
    endcase

    // Seconds only accumulate while staying in SPIN; any exit clears them.
    sec_next = '0;
    if (state_reg == SPIN && state_next == SPIN) begin
      sec_next = sec_reg + {3'b000, sec_tick_p};
    end

    spin_en_next = (state_next == SPIN);
    latch_next   = (state_next == STOP);
    eval_next    = (state_next == EVAL);
  end

  assign cur_state = state_reg;
  assign credits   = credits_reg;
  assign spin_en   = spin_en_reg;
  assign latch_p   = latch_reg;
  assign eval_p    = eval_reg;
  assign clear_p   = clear_reg;

endmodule

// File: tb/tb_bandit_ctrl.sv
module tb_bandit_ctrl;
  import bandit_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_p, start_p, stop_p, score_reset;
  logic [3:0] cur_state, credits;
  logic       spin_en, latch_p, eval_p, clear_p;

  int passed = 0;
  int total  = 0;

  bandit_ctrl #(.CLK_HZ(10), .SPIN_SEC(3), .MAX_CREDIT(9)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coin_p     (coin_p),
    .start_p    (start_p),
    .stop_p     (stop_p),
    .score_reset(score_reset),
    .cur_state  (cur_state),
    .credits    (credits),
    .spin_en    (spin_en),
    .latch_p    (latch_p),
    .eval_p     (eval_p),
    .clear_p    (clear_p)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic [3:0] st, input logic [3:0] cr,
                           input logic sp, input logic la, input logic ev, input logic cl);
    chk({tag, ".state"},   cur_state, st);
    chk({tag, ".credits"}, credits, cr);
    chk({tag, ".spin_en"}, {3'b000, spin_en}, {3'b000, sp});
    chk({tag, ".latch_p"}, {3'b000, latch_p}, {3'b000, la});
    chk({tag, ".eval_p"},  {3'b000, eval_p},  {3'b000, ev});
    chk({tag, ".clear_p"}, {3'b000, clear_p}, {3'b000, cl});
    $display("step %-14s state=%0h credits=%0d spin=%0b latch=%0b eval=%0b clear=%0b",
             tag, cur_state, credits, spin_en, latch_p, eval_p, clear_p);
  endtask

  initial begin
    rst_n = 1'b0; coin_p = 1'b0; start_p = 1'b0; stop_p = 1'b0; score_reset = 1'b0;
    repeat (2) step();
    check_out("reset", IDLE, 4'd0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(); check_out("idle", IDLE, 4'd0, 0, 0, 0, 0);

    // Single credit, auto-stop after 3 s of 10 cycles
    coin_p = 1; step(); coin_p = 0;   check_out("coin1", COIN, 4'd1, 0, 0, 0, 0);
    start_p = 1; step(); start_p = 0; check_out("spin_entry", SPIN, 4'd0, 1, 0, 0, 0);
    repeat (29) step();               check_out("spin_29", SPIN, 4'd0, 1, 0, 0, 0);
    step();                           check_out("auto_stop", STOP, 4'd0, 0, 1, 0, 0);
    step();                           check_out("eval0", EVAL, 4'd0, 0, 0, 1, 0);
    step();                           check_out("wait0", WAIT, 4'd0, 0, 0, 0, 0);
    step();                           check_out("wait_hold", WAIT, 4'd0, 0, 0, 0, 0);

    // Countdown expiry clears score and idles, pulse only once
    score_reset = 1; step();          check_out("clear", IDLE, 4'd0, 0, 0, 0, 1);
    step(); score_reset = 0;          check_out("clear_once", IDLE, 4'd0, 0, 0, 0, 0);

    // Lever/stop ignored in IDLE
    start_p = 1; step(); start_p = 0; check_out("idle_start", IDLE, 4'd0, 0, 0, 0, 0);
    stop_p = 1; step(); stop_p = 0;   check_out("idle_stop", IDLE, 4'd0, 0, 0, 0, 0);

    // Two back-to-back coins, manual stop 4 cycles after start
    coin_p = 1; step();               check_out("coin_a", COIN, 4'd1, 0, 0, 0, 0);
    step(); coin_p = 0;               check_out("coin_b", COIN, 4'd2, 0, 0, 0, 0);
    start_p = 1; step();              check_out("spin2", SPIN, 4'd1, 1, 0, 0, 0);
    step(); start_p = 0;              check_out("spin_start_ign", SPIN, 4'd1, 1, 0, 0, 0);
    step(); step();                   check_out("spin2_run", SPIN, 4'd1, 1, 0, 0, 0);
    stop_p = 1; step(); stop_p = 0;   check_out("manual_stop", STOP, 4'd1, 0, 1, 0, 0);
    step();                           check_out("eval1", EVAL, 4'd1, 0, 0, 1, 0);
    step();                           check_out("back_coin", COIN, 4'd1, 0, 0, 0, 0);

    // Spend last credit, then coin beats score_reset in WAIT
    start_p = 1; step(); start_p = 0; check_out("spin3", SPIN, 4'd0, 1, 0, 0, 0);
    stop_p = 1; step(); stop_p = 0;   check_out("stop3", STOP, 4'd0, 0, 1, 0, 0);
    step();                           check_out("eval3", EVAL, 4'd0, 0, 0, 1, 0);
    step();                           check_out("wait3", WAIT, 4'd0, 0, 0, 0, 0);
    coin_p = 1; score_reset = 1; step(); coin_p = 0; score_reset = 0;
    check_out("coin_wins", COIN, 4'd1, 0, 0, 0, 0);

    // Back to IDLE for the saturation test
    start_p = 1; step(); start_p = 0; check_out("spin4", SPIN, 4'd0, 1, 0, 0, 0);
    stop_p = 1; step(); stop_p = 0;   check_out("stop4", STOP, 4'd0, 0, 1, 0, 0);
    step(); step();                   check_out("wait4", WAIT, 4'd0, 0, 0, 0, 0);
    score_reset = 1; step(); score_reset = 0;
    check_out("clear4", IDLE, 4'd0, 0, 0, 0, 1);

    coin_p = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      check_out($sformatf("coin_sat%0d", i), COIN, (i < 9) ? 4'(i + 1) : 4'd9, 0, 0, 0, 0);
    end
    start_p = 1; step(); start_p = 0; check_out("coin_start_max", SPIN, 4'd8, 1, 0, 0, 0);
    step();                           check_out("spin_coin", SPIN, 4'd9, 1, 0, 0, 0);
    step(); coin_p = 0;               check_out("spin_coin_sat", SPIN, 4'd9, 1, 0, 0, 0);
    repeat (12) step();               check_out("spin_c15", SPIN, 4'd9, 1, 0, 0, 0);

    // Asynchronous abort mid-spin, no clock edge needed
    rst_n = 0; #1;                    check_out("async_rst", IDLE, 4'd0, 0, 0, 0, 0);
    step(); rst_n = 1;

    // Timer restarts from zero: exactly 30 cycles of SPIN again
    coin_p = 1; step(); coin_p = 0;   check_out("coin_r", COIN, 4'd1, 0, 0, 0, 0);
    start_p = 1; step(); start_p = 0; check_out("spin_r", SPIN, 4'd0, 1, 0, 0, 0);
    repeat (29) step();               check_out("spin_r29", SPIN, 4'd0, 1, 0, 0, 0);
    step();                           check_out("auto_stop_r", STOP, 4'd0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
